b213_seq_sched: RTL and testbench
=================================

B213_SEQ_SCHED -- requirements
Module: b213_seq_sched

Interface
REQ-001 Parameter SEQ_LEN, default 32: code symbols (2-bit Rx pairs) fed to the decoder per sequence, legal range 4..255.
REQ-002 Parameter TIMEOUT, default 255: maximum DRAIN cycles without decoder oe before abort, legal range 16..255.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset; both are listed below.
REQ-004 clock  in  1  single rising-edge clock for all state.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 in_data  in  2  upstream received code bits, [1] first in time.
REQ-007 in_valid  in  1  in_data valid.
REQ-008 in_ready  out  1  block accepts in_data this cycle.
REQ-009 Rx  out  2  symbol to decoder Rx.
REQ-010 seq_ready  out  1  one-cycle pulse to decoder seq_ready; starts a sequence.
REQ-011 Dx  in  1  decoded bit from decoder.
REQ-012 oe  in  1  decoder output enable.
REQ-013 sync_error  in  1  decoder sync error flag.
REQ-014 out_data  out  1  decoded bit to downstream.
REQ-015 out_valid  out  1  out_data valid.
REQ-016 out_last  out  1  marks the final decoded bit of a sequence.
REQ-017 phase  out  1  current bit-alignment phase.
REQ-018 slip_cnt  out  8  count of alignment slips, saturating.
REQ-019 underrun  out  1  sticky: in_valid was low during LOAD in the current sequence.
REQ-020 timeout_err  out  1  one-cycle pulse on DRAIN timeout.

Function
REQ-021 The FSM SHALL have exactly the states IDLE, LOAD, FLUSH, DRAIN and SLIP, and SHALL update only on rising clock edges.
REQ-022 IDLE: in_ready=0 and Rx=00; the block SHALL go to LOAD on the first cycle with in_valid=1, with seq_ready high during the first LOAD cycle only.
REQ-023 LOAD: in_ready=1 and sym_cnt counts accepted symbols; after SEQ_LEN accepts the block SHALL go to FLUSH.
REQ-024 Each in_valid&in_ready accept SHALL drive the aligned symbol on Rx one cycle later (registered output).
REQ-025 LOAD with in_valid=0: no accept, next Rx=00, underrun set, sym_cnt unchanged; underrun SHALL clear on the IDLE->LOAD transition.
REQ-026 Alignment, phase=0: symbol = in_data.
REQ-027 Alignment, phase=1: symbol = {held_bit, in_data[1]} and held_bit <= in_data[0]; held_bit is 0 on the first accept after a slip.
REQ-028 FLUSH: exactly 2 cycles with Rx=00 (encoder tail) and in_ready=0, then the block SHALL go to DRAIN.
REQ-029 DRAIN: each cycle with oe=1 SHALL produce out_valid=1 and out_data=Dx on the next cycle, and increment out_cnt.
REQ-030 The SEQ_LEN-th output SHALL carry out_last=1; the block SHALL then go to SLIP if slip_pend=1, else to IDLE.
REQ-031 Outside DRAIN, oe SHALL be ignored and out_valid SHALL be 0.
REQ-032 The DRAIN idle counter SHALL reset on every oe=1; reaching TIMEOUT consecutive cycles with oe=0 SHALL pulse timeout_err, give no out_last, and go to SLIP if slip_pend=1, else to IDLE.
REQ-033 sync_error=1 in any cycle of LOAD, FLUSH or DRAIN SHALL set slip_pend; slip_pend SHALL clear on entry to SLIP.
REQ-034 SLIP lasts one cycle: phase toggles, held_bit clears, slip_cnt increments and saturates at 255, then the block SHALL go to IDLE.
REQ-035 If sync_error and sequence completion occur in the same cycle, the completing sequence SHALL take the SLIP path.
REQ-036 in_ready SHALL be 0 in every state other than LOAD.

Reset
REQ-037 While reset=0, and immediately on its assertion, the block SHALL go to IDLE with all outputs 0 and phase, held_bit, slip_pend, sym_cnt, out_cnt, idle counter and slip_cnt all 0.
REQ-038 Reset asserted mid-sequence SHALL abort with no out_last, and the first cycle after release SHALL behave as IDLE.

Verification
REQ-039 SEQ_LEN=4, continuous in_valid, symbols 11,01,10,00 -> seq_ready pulse, Rx 11,01,10,00,00,00; decoder gives 4 oe -> out_data matches, out_last on the 4th.
REQ-040 in_valid low for 2 cycles mid-LOAD -> Rx=00 for those cycles, underrun=1, sym_cnt holds, sequence completes after 4 accepts.
REQ-041 sync_error pulse during FLUSH -> after out_last, one SLIP cycle, phase=1, slip_cnt=1; next inputs 10,11 -> Rx 01,01.
REQ-042 No oe in DRAIN, TIMEOUT=16 -> timeout_err pulse 16 cycles after DRAIN entry, no out_last, return to IDLE.
REQ-043 Force 256 slips -> slip_cnt holds at 255.
REQ-044 Reset asserted in DRAIN with in_valid=1 -> all outputs 0 asynchronously; after release, new seq_ready pulse and phase=0.

Source files
------------

// File: rtl/b213_seq_sched.sv
// b213_seq_sched: feeds fixed-length code-symbol sequences to a decoder,
// realigns the 2-bit pairs by one bit after sync loss, and drains results.
// Ports:
//   clock, reset (async, active-low)
//   in_data/in_valid/in_ready   upstream code bits, [1] first in time
//   Rx/seq_ready                symbol stream and sequence start to decoder
//   Dx/oe/sync_error            decoder result, output enable, sync loss
//   out_data/out_valid/out_last decoded bit stream to downstream
//   phase/slip_cnt              alignment phase, saturating slip count
//   underrun/timeout_err        sticky LOAD starvation, DRAIN abort pulse
module b213_seq_sched #(
    parameter int SEQ_LEN = 32,
    parameter int TIMEOUT = 255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [1:0] Rx,
    output logic       seq_ready,
    input  logic       Dx,
    input  logic       oe,
    input  logic       sync_error,
    output logic       out_data,
    output logic       out_valid,
    output logic       out_last,
    output logic       phase,
    output logic [7:0] slip_cnt,
    output logic       underrun,
    output logic       timeout_err
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FLUSH,
        DRAIN,
        SLIP
    } state_t;

    localparam logic [7:0] LEN_M1 = 8'(SEQ_LEN - 1);
    localparam logic [7:0] TMO_M1 = 8'(TIMEOUT - 1);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_sym_cnt;
    logic [7:0] r_out_cnt;
    logic [7:0] r_idle_cnt;
    logic [7:0] r_slip_cnt;
    logic [1:0] r_rx;
    logic       r_phase;
    logic       r_held;
    logic       r_slip_pend;
    logic       r_flush;
    logic       r_underrun;
    logic       r_seq_ready;
    logic       r_out_data;
    logic       r_out_valid;
    logic       r_out_last;
    logic       r_timeout;

    logic [1:0] w_sym;
    logic       w_accept;
    logic       w_last_in;
    logic       w_oe;
    logic       w_out_done;
    logic       w_tmo;
    logic       w_active;

    assign w_accept   = (r_state == LOAD) && in_valid;
    assign w_last_in  = w_accept && (r_sym_cnt == LEN_M1);
    assign w_oe       = (r_state == DRAIN) && oe;
    assign w_out_done = w_oe && (r_out_cnt == LEN_M1);
    assign w_tmo      = (r_state == DRAIN) && !oe && (r_idle_cnt == TMO_M1);
    assign w_active   = (r_state == LOAD) || (r_state == FLUSH) ||
                        (r_state == DRAIN);
    // Phase 1 pairs the bit held from the previous accept with the new MSB.
    assign w_sym      = r_phase ? {r_held, in_data[1]} : in_data;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (in_valid) w_next = LOAD;
            LOAD:  if (w_last_in) w_next = FLUSH;
            FLUSH: if (r_flush) w_next = DRAIN;
            DRAIN: begin
                // A sync error in the finishing cycle still forces a slip.
                if (w_out_done || w_tmo) begin
                    w_next = (r_slip_pend || sync_error) ? SLIP : IDLE;
                end
            end
            SLIP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sym_cnt   <= 8'd0;
            r_out_cnt   <= 8'd0;
            r_idle_cnt  <= 8'd0;
            r_slip_cnt  <= 8'd0;
            r_rx        <= 2'b00;
            r_phase     <= 1'b0;
            r_held      <= 1'b0;
            r_slip_pend <= 1'b0;
            r_flush     <= 1'b0;
            r_underrun  <= 1'b0;
            r_seq_ready <= 1'b0;
            r_out_data  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_seq_ready <= (r_state == IDLE) && in_valid;
            r_rx        <= w_accept ? w_sym : 2'b00;
            r_flush     <= (r_state == FLUSH) && !r_flush;
            r_out_valid <= w_oe;
            r_out_data  <= w_oe && Dx;
            r_out_last  <= w_out_done;
            r_timeout   <= w_tmo;

            if (w_accept) begin
                r_sym_cnt <= w_last_in ? 8'd0 : r_sym_cnt + 8'd1;
            end

            if ((r_state == IDLE) && in_valid) begin
                r_underrun <= 1'b0;
            end else if ((r_state == LOAD) && !in_valid) begin
                r_underrun <= 1'b1;
            end

            if (w_oe) begin
                r_out_cnt <= w_out_done ? 8'd0 : r_out_cnt + 8'd1;
            end else if (w_tmo) begin
                r_out_cnt <= 8'd0;
            end

            if ((r_state == DRAIN) && !oe && !w_tmo) begin
                r_idle_cnt <= r_idle_cnt + 8'd1;
            end else begin
                r_idle_cnt <= 8'd0;
            end

            if (w_next == SLIP) begin
                r_slip_pend <= 1'b0;
            end else if (w_active && sync_error) begin
                r_slip_pend <= 1'b1;
            end

            if (r_state == SLIP) begin
                r_phase <= !r_phase;
                r_held  <= 1'b0;
                if (r_slip_cnt != 8'hFF) begin
                    r_slip_cnt <= r_slip_cnt + 8'd1;
                end
            end else if (w_accept && r_phase) begin
                r_held <= in_data[0];
            end
        end
    end

    assign in_ready    = (r_state == LOAD);
    assign Rx          = r_rx;
    assign seq_ready   = r_seq_ready;
    assign out_data    = r_out_data;
    assign out_valid   = r_out_valid;
    assign out_last    = r_out_last;
    assign phase       = r_phase;
    assign slip_cnt    = r_slip_cnt;
    assign underrun    = r_underrun;
    assign timeout_err = r_timeout;

endmodule

// File: tb/tb_b213_seq_sched.sv
// tb_b213_seq_sched: scoreboard bench for b213_seq_sched
// with SEQ_LEN=4 and TIMEOUT=16.
module tb_b213_seq_sched;

    logic       clock;
    logic       reset;
    logic [1:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] Rx;
    logic       seq_ready;
    logic       Dx;
    logic       oe;
    logic       sync_error;
    logic       out_data;
    logic       out_valid;
    logic       out_last;
    logic       phase;
    logic [7:0] slip_cnt;
    logic       underrun;
    logic       timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [1:0] rx_q[$];
    logic       out_q[$];
    logic [17:0] w_all;

    b213_seq_sched #(
        .SEQ_LEN(4),
        .TIMEOUT(16)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .Rx         (Rx),
        .seq_ready  (seq_ready),
        .Dx         (Dx),
        .oe         (oe),
        .sync_error (sync_error),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .phase      (phase),
        .slip_cnt   (slip_cnt),
        .underrun   (underrun),
        .timeout_err(timeout_err)
    );

    assign w_all = {in_ready, Rx, seq_ready, out_data, out_valid,
                    out_last, phase, slip_cnt, underrun, timeout_err};

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "bench stuck");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic rx_step(input logic [1:0] exp);
        rx_q.push_back(exp);
        tick();
        chk("rx", 32'(Rx), 32'(rx_q.pop_front()));
    endtask

    task automatic run_seq(input logic [7:0] syms, input logic [7:0] exp_rx,
                           input int gap_at, input int gap_len,
                           input bit sync_flush, input bit do_drain,
                           input logic [3:0] dbits);
        in_valid = 1'b1;
        in_data  = syms[7:6];
        tick();
        chk("sr_start", 32'(seq_ready), 1);
        chk("rdy_load", 32'(in_ready), 1);
        chk("rx_idle", 32'(Rx), 0);
        chk("ur_clear", 32'(underrun), 0);
        for (int i = 0; i < 4; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    in_valid = 1'b0;
                    rx_step(2'b00);
                end
                chk("underrun", 32'(underrun), 1);
            end
            in_valid = 1'b1;
            in_data  = syms[(7 - 2 * i) -: 2];
            rx_step(exp_rx[(7 - 2 * i) -: 2]);
            if (i == 0) chk("sr_pulse", 32'(seq_ready), 0);
        end
        in_valid   = 1'b0;
        sync_error = sync_flush;
        oe         = 1'b1;
        Dx         = 1'b1;
        rx_step(2'b00);
        chk("rdy_flush", 32'(in_ready), 0);
        sync_error = 1'b0;
        rx_step(2'b00);
        chk("ov_flush", 32'(out_valid), 0);
        oe = 1'b0;
        if (do_drain) begin
            tick();
            chk("ov_idle", 32'(out_valid), 0);
            for (int k = 0; k < 4; k++) begin
                oe = 1'b1;
                Dx = dbits[3 - k];
                out_q.push_back(Dx);
                tick();
                if (out_valid) begin
                    chk("dout", 32'(out_data), 32'(out_q.pop_front()));
                end else begin
                    chk("ovalid", 32'(out_valid), 1);
                end
                chk("olast", 32'(out_last), (k == 3) ? 1 : 0);
            end
            oe = 1'b0;
        end
    endtask

    task automatic quick_slip();
        in_valid   = 1'b1;
        in_data    = 2'b00;
        sync_error = 1'b0;
        tick();
        sync_error = 1'b1;
        repeat (4) tick();
        sync_error = 1'b0;
        in_valid   = 1'b0;
        repeat (2) tick();
        oe = 1'b1;
        repeat (4) tick();
        oe = 1'b0;
        tick();
    endtask

    initial begin
        int n;
        reset      = 1'b0;
        in_data    = 2'b00;
        in_valid   = 1'b0;
        Dx         = 1'b0;
        oe         = 1'b0;
        sync_error = 1'b0;
        #2;
        chk("reset_all", 32'(w_all), 0);
        #10;
        reset = 1'b1;
        tick();
        chk("idle_rdy", 32'(in_ready), 0);

        run_seq(8'b11_01_10_00, 8'b11_01_10_00, -1, 0, 0, 1, 4'b1011);
        tick();
        chk("phase0", 32'(phase), 0);

        run_seq(8'b01_10_11_00, 8'b01_10_11_00, 2, 2, 0, 1, 4'b0110);
        tick();

        run_seq(8'b10_10_01_01, 8'b10_10_01_01, -1, 0, 0, 0, 4'b0000);
        n = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (timeout_err) begin
                n = c;
                break;
            end
        end
        chk("tmo_cycles", 32'(n), 16);
        chk("tmo_nolast", 32'(out_last), 0);
        tick();
        chk("tmo_pulse", 32'(timeout_err), 0);

        run_seq(8'b11_01_10_00, 8'b11_01_10_00, -1, 0, 1, 1, 4'b1100);
        tick();
        chk("slip_phase", 32'(phase), 1);
        chk("slip_cnt1", 32'(slip_cnt), 1);
        run_seq(8'b10_11_01_00, 8'b01_01_10_10, -1, 0, 0, 1, 4'b0101);
        tick();
        chk("phase_hold", 32'(phase), 1);

        run_seq(8'b00_00_00_00, 8'b00_00_00_00, -1, 0, 0, 0, 4'b0000);
        in_valid = 1'b1;
        oe       = 1'b1;
        Dx       = 1'b1;
        out_q.push_back(Dx);
        tick();
        chk("rst_ov", 32'(out_valid), 1);
        chk("rst_dout", 32'(out_data), 32'(out_q.pop_front()));
        oe = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("rst_async", 32'(w_all), 0);
        @(negedge clock);
        reset = 1'b1;
        tick();
        chk("rst_sr", 32'(seq_ready), 1);
        chk("rst_phase", 32'(phase), 0);
        in_valid = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        reset = 1'b1;
        tick();

        for (int i = 0; i < 256; i++) begin
            quick_slip();
            chk("sat_cnt", 32'(slip_cnt), (i + 1 > 255) ? 255 : i + 1);
            chk("sat_phase", 32'(phase), (i + 1) % 2);
        end

        chk("q_empty", 32'(out_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
